dest_drain: RTL and testbench

- Downstream consumer of the two destination FIFOs (D0/D1) at the output of the PCIe interconnect.
- Arbitrates round-robin between the two FIFOs and issues their pop strobes.
- Captures the one-cycle-late FIFO read data into a 2-entry output queue and presents one valid/ready word stream tagged with its source destination.
- Keeps per-destination delivered-word counters for the testbench and status logic.

---
 rtl/dest_drain_pkg.sv | 13 +
 rtl/dest_drain_if.sv | 32 +++
 rtl/dest_drain_queue.sv | 46 ++++
 rtl/dest_drain.sv | 179 +++++++++++++++++
 tb/tb_dest_drain.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dest_drain_pkg.sv
// Shared types for the destination-FIFO drain block: FSM encoding and source ids.
package dest_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

endpackage

// File: rtl/dest_drain_if.sv
// Bus bundle between the destination FIFOs / sink and dest_drain.
interface dest_drain_if #(
    parameter int WORD_SIZE = 6,
    parameter int CNT_W     = 8
);
    logic                 enable;
    logic                 d0_empty;
    logic                 d1_empty;
    logic [WORD_SIZE-1:0] d0_data;
    logic [WORD_SIZE-1:0] d1_data;
    logic                 pop_D0;
    logic                 pop_D1;
    logic                 ready_in;
    logic                 valid_out;
    logic [WORD_SIZE-1:0] data_out;
    logic                 dest_out;
    logic                 clear_cnt;
    logic [CNT_W-1:0]     cnt_d0;
    logic [CNT_W-1:0]     cnt_d1;
    logic                 busy;
    logic                 dest_err;

    modport slave (
        input  enable, d0_empty, d1_empty, d0_data, d1_data, ready_in, clear_cnt,
        output pop_D0, pop_D1, valid_out, data_out, dest_out, cnt_d0, cnt_d1, busy, dest_err
    );

    modport master (
        output enable, d0_empty, d1_empty, d0_data, d1_data, ready_in, clear_cnt,
        input  pop_D0, pop_D1, valid_out, data_out, dest_out, cnt_d0, cnt_d1, busy, dest_err
    );
endinterface

// File: rtl/dest_drain_queue.sv
// Two-entry output queue; head entry drives the valid/ready stream.
module dest_drain_queue #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic         r_head;
    logic         r_tail;
    logic [1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_data;
                r_tail        <= ~r_tail;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/dest_drain.sv
// Round-robin drain of FIFO_D0/D1 into a tagged valid/ready stream with delivery counters.
// Define DEST_DRAIN_CHECK_EN to add the sticky destination-selector mismatch flag.
module dest_drain
    import dest_drain_pkg::*;
#(
    parameter int WORD_SIZE = 6,
    parameter int CNT_W     = 8,
    parameter int DEST_BIT  = 4
) (
    input  logic        clk,
    input  logic        reset_L,
    dest_drain_if.slave bus
);
    if (DEST_BIT < 0 || DEST_BIT >= WORD_SIZE) begin : g_bad_dest_bit
        $error("dest_drain: DEST_BIT must index a bit of the word");
    end

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_ptr;
    logic                 r_inflight;
    logic                 r_inflight_src;
    logic [CNT_W-1:0]     r_cnt_d0;
    logic [CNT_W-1:0]     r_cnt_d1;

    logic                 w_cand_ok;
    logic                 w_cand_src;
    logic                 w_room;
    logic                 w_pop;
    logic                 w_pop_d0;
    logic                 w_pop_d1;
    logic                 w_busy;
    logic                 w_dep;
    logic                 w_q_valid;
    logic [1:0]           w_q_count;
    logic [2:0]           w_occ;
    logic [WORD_SIZE-1:0] w_cap_data;
    logic [WORD_SIZE:0]   w_head;

    // Occupancy counts the word already in flight so a pop never overfills the queue.
    assign w_dep  = w_q_valid & bus.ready_in;
    assign w_occ  = {1'b0, w_q_count} + {2'b0, r_inflight} - {2'b0, w_dep};
    assign w_room = (w_occ < 3'd2);

    always_comb begin
        w_cand_ok  = 1'b0;
        w_cand_src = DEST_D0;
        if (r_ptr == DEST_D0) begin
            if (!bus.d0_empty) begin
                w_cand_ok  = 1'b1;
                w_cand_src = DEST_D0;
            end else if (!bus.d1_empty) begin
                w_cand_ok  = 1'b1;
                w_cand_src = DEST_D1;
            end
        end else begin
            if (!bus.d1_empty) begin
                w_cand_ok  = 1'b1;
                w_cand_src = DEST_D1;
            end else if (!bus.d0_empty) begin
                w_cand_ok  = 1'b1;
                w_cand_src = DEST_D0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.enable) w_next_state = RUN;
            RUN:     if (!bus.enable) w_next_state = DRAIN;
            DRAIN: begin
                if (bus.enable) begin
                    w_next_state = RUN;
                end else if (!r_inflight && (w_q_count == 2'd0)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != IDLE);
        w_pop    = 1'b0;
        w_pop_d0 = 1'b0;
        w_pop_d1 = 1'b0;
        if ((r_state == RUN) && w_cand_ok && w_room) begin
            w_pop    = 1'b1;
            w_pop_d0 = (w_cand_src == DEST_D0);
            w_pop_d1 = (w_cand_src == DEST_D1);
        end
    end

    // Pointer parks on the FIFO that was not just served.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_ptr          <= DEST_D0;
            r_inflight     <= 1'b0;
            r_inflight_src <= DEST_D0;
        end else begin
            r_inflight <= w_pop;
            if (w_pop) begin
                r_inflight_src <= w_cand_src;
                r_ptr          <= ~w_cand_src;
            end
        end
    end

    assign w_cap_data = (r_inflight_src == DEST_D1) ? bus.d1_data : bus.d0_data;

    dest_drain_queue #(
        .W(WORD_SIZE + 1)
    ) u_queue (
        .clk         (clk),
        .rst_n       (reset_L),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_src, w_cap_data}),
        .i_pop       (w_dep),
        .o_valid     (w_q_valid),
        .o_head      (w_head),
        .o_count     (w_q_count)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt_d0 <= '0;
            r_cnt_d1 <= '0;
        end else if (bus.clear_cnt) begin
            r_cnt_d0 <= '0;
            r_cnt_d1 <= '0;
        end else if (w_dep) begin
            if (w_head[WORD_SIZE] == DEST_D1) begin
                r_cnt_d1 <= r_cnt_d1 + CNT_W'(1);
            end else begin
                r_cnt_d0 <= r_cnt_d0 + CNT_W'(1);
            end
        end
    end

`ifdef DEST_DRAIN_CHECK_EN
    logic r_dest_err;
    logic w_mismatch;

    assign w_mismatch = r_inflight & (w_cap_data[DEST_BIT] != r_inflight_src);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_dest_err <= 1'b0;
        end else if (w_mismatch) begin
            r_dest_err <= 1'b1;
        end else if (bus.clear_cnt) begin
            r_dest_err <= 1'b0;
        end
    end

    assign bus.dest_err = r_dest_err;
`else
    assign bus.dest_err = 1'b0;
`endif

    assign bus.pop_D0    = w_pop_d0;
    assign bus.pop_D1    = w_pop_d1;
    assign bus.busy      = w_busy;
    assign bus.valid_out = w_q_valid;
    assign bus.data_out  = w_head[WORD_SIZE-1:0];
    assign bus.dest_out  = w_head[WORD_SIZE];
    assign bus.cnt_d0    = r_cnt_d0;
    assign bus.cnt_d1    = r_cnt_d1;

endmodule

// File: tb/tb_dest_drain.sv
// Bench for dest_drain: FIFO environment, queue-based reference model, directed and random steps.
module tb_dest_drain;
    localparam int WS = 6;
    localparam int CW = 8;
    localparam int DB = 4;

    logic clk     = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    dest_drain_if #(.WORD_SIZE(WS), .CNT_W(CW)) bus ();
    dest_drain_if #(.WORD_SIZE(WS), .CNT_W(2))  bus2 ();

    dest_drain #(.WORD_SIZE(WS), .CNT_W(CW), .DEST_BIT(DB)) dut (
        .clk(clk), .reset_L(reset_L), .bus(bus)
    );
    dest_drain #(.WORD_SIZE(WS), .CNT_W(2), .DEST_BIT(DB)) dut2 (
        .clk(clk), .reset_L(reset_L), .bus(bus2)
    );

    assign bus2.enable    = bus.enable;
    assign bus2.d0_empty  = bus.d0_empty;
    assign bus2.d1_empty  = bus.d1_empty;
    assign bus2.d0_data   = bus.d0_data;
    assign bus2.d1_data   = bus.d1_data;
    assign bus2.ready_in  = bus.ready_in;
    assign bus2.clear_cnt = bus.clear_cnt;

    int checks = 0;
    int errors = 0;
    int n_deliv = 0;
    int n_pops;

    logic [WS-1:0] f0 [$];
    logic [WS-1:0] f1 [$];

    logic [WS:0] m_q [$];
    int          m_inflight = -1;
    bit          m_ptr = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_run = 1'b0;
    bit          m_err = 1'b0;
    int          m_c0 = 0;
    int          m_c1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs, advance the model, then let the FIFOs respond.
    task automatic cyc();
        logic          vld, dep, pop, p0, p1, set_err;
        logic [WS:0]   hd;
        logic [WS-1:0] w;
        int            cand, occ, q_before, inf_before;
        #2;
        vld  = (m_q.size() > 0);
        hd   = vld ? m_q[0] : '0;
        dep  = vld && bus.ready_in;
        cand = -1;
        if (m_ptr == 1'b0) cand = !bus.d0_empty ? 0 : (!bus.d1_empty ? 1 : -1);
        else               cand = !bus.d1_empty ? 1 : (!bus.d0_empty ? 0 : -1);
        occ  = m_q.size() + ((m_inflight >= 0) ? 1 : 0) - (dep ? 1 : 0);
        pop  = m_busy && m_run && (cand >= 0) && (occ < 2);

        chk("pop_D0", bus.pop_D0, pop && cand == 0);
        chk("pop_D1", bus.pop_D1, pop && cand == 1);
        chk("pop2_D0", bus2.pop_D0, pop && cand == 0);
        chk("pop2_D1", bus2.pop_D1, pop && cand == 1);
        chk("valid_out", bus.valid_out, vld);
        if (vld) begin
            chk("data_out", bus.data_out, hd[WS-1:0]);
            chk("dest_out", bus.dest_out, hd[WS]);
        end
        chk("busy", bus.busy, m_busy);
        chk("cnt_d0", bus.cnt_d0, m_c0 % 256);
        chk("cnt_d1", bus.cnt_d1, m_c1 % 256);
        chk("cnt2_d0", bus2.cnt_d0, m_c0 % 4);
        chk("cnt2_d1", bus2.cnt_d1, m_c1 % 4);
        chk("dest_err", bus.dest_err, m_err);

        if (bus.valid_out && bus.ready_in) n_deliv++;
        p0 = bus.pop_D0;
        p1 = bus.pop_D1;

        q_before   = m_q.size();
        inf_before = m_inflight;
        if (dep) m_q.delete(0);
        if (bus.clear_cnt) begin
            m_c0 = 0;
            m_c1 = 0;
        end else if (dep) begin
            if (hd[WS]) m_c1++;
            else        m_c0++;
        end
        set_err = 1'b0;
        if (m_inflight >= 0) begin
            w = (m_inflight == 1) ? bus.d1_data : bus.d0_data;
            m_q.push_back({m_inflight == 1, w});
`ifdef DEST_DRAIN_CHECK_EN
            if (w[DB] != (m_inflight == 1)) set_err = 1'b1;
`endif
        end
        if (set_err) m_err = 1'b1;
        else if (bus.clear_cnt) m_err = 1'b0;

        if (!m_busy) begin
            if (bus.enable) begin m_busy = 1'b1; m_run = 1'b1; end
        end else if (m_run) begin
            if (!bus.enable) m_run = 1'b0;
        end else if (bus.enable) begin
            m_run = 1'b1;
        end else if (inf_before < 0 && q_before == 0) begin
            m_busy = 1'b0;
        end
        m_inflight = pop ? cand : -1;
        if (pop) m_ptr = (cand == 0);

        @(posedge clk);
        #1;
        if (p0 && f0.size() > 0) bus.d0_data = f0.pop_front();
        if (p1 && f1.size() > 0) bus.d1_data = f1.pop_front();
        bus.d0_empty = (f0.size() == 0);
        bus.d1_empty = (f1.size() == 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        chk("rst_pop_D0", bus.pop_D0, 1'b0);
        chk("rst_pop_D1", bus.pop_D1, 1'b0);
        chk("rst_valid", bus.valid_out, 1'b0);
        chk("rst_data", bus.data_out, 6'h00);
        chk("rst_dest", bus.dest_out, 1'b0);
        chk("rst_cnt_d0", bus.cnt_d0, 8'h00);
        chk("rst_cnt_d1", bus.cnt_d1, 8'h00);
        chk("rst_cnt2_d1", bus2.cnt_d1, 2'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_dest_err", bus.dest_err, 1'b0);
        m_q.delete();
        m_inflight = -1;
        m_ptr  = 1'b0;
        m_busy = 1'b0;
        m_run  = 1'b0;
        m_err  = 1'b0;
        m_c0   = 0;
        m_c1   = 0;
        @(posedge clk);
        #1;
        bus.d0_empty = (f0.size() == 0);
        bus.d1_empty = (f1.size() == 0);
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic run_until_idle(input string tag);
        for (int i = 0; i < 40 && bus.busy; i++) cyc();
        chk(tag, bus.busy, 1'b0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !bus.valid_out; i++) cyc();
        chk(tag, bus.valid_out, 1'b1);
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.ready_in  = 1'b0;
        bus.clear_cnt = 1'b0;
        bus.d0_empty  = 1'b1;
        bus.d1_empty  = 1'b1;
        bus.d0_data   = '0;
        bus.d1_data   = '0;
        @(negedge clk);
        do_reset();
        repeat (3) cyc();

        // single-FIFO latency: enable rises in cycle 0
        f0.push_back(6'h05);
        f0.push_back(6'h0A);
        cyc();
        bus.enable   = 1'b1;
        bus.ready_in = 1'b1;
        cyc();
        chk("lat_c1_pop_D0", bus.pop_D0, 1'b1);
        cyc();
        chk("lat_c2_pop_D0", bus.pop_D0, 1'b1);
        cyc();
        chk("lat_c3_valid", bus.valid_out, 1'b1);
        chk("lat_c3_data", bus.data_out, 6'h05);
        chk("lat_c3_dest", bus.dest_out, 1'b0);
        cyc();
        chk("lat_c4_valid", bus.valid_out, 1'b1);
        chk("lat_c4_data", bus.data_out, 6'h0A);
        chk("lat_c4_dest", bus.dest_out, 1'b0);
        cyc();
        chk("lat_cnt_d0", bus.cnt_d0, 8'd2);
        bus.enable = 1'b0;
        run_until_idle("lat_idle");

        // round-robin with both FIFOs holding four words
        do_reset();
        for (int i = 0; i < 4; i++) begin
            f0.push_back(6'(8'h01 + i));
            f1.push_back(6'(8'h11 + i));
        end
        cyc();
        bus.enable   = 1'b1;
        bus.ready_in = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk("rr_pop_D0", bus.pop_D0, (i % 2) == 0);
            chk("rr_pop_D1", bus.pop_D1, (i % 2) == 1);
            cyc();
        end
        repeat (4) cyc();
        chk("rr_cnt_d0", bus.cnt_d0, 8'd4);
        chk("rr_cnt_d1", bus.cnt_d1, 8'd4);

        // backpressure: two pops fill the queue, head held
        bus.ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f0.push_back(6'(8'h21 + i));
            f1.push_back(6'(8'h31 + i));
        end
        n_pops = 0;
        for (int i = 0; i < 8; i++) begin
            n_pops += int'(bus.pop_D0) + int'(bus.pop_D1);
            cyc();
            if (i >= 3) chk("bp_head_stable", bus.data_out, 6'h21);
        end
        chk("bp_pops", n_pops, 2);
        bus.ready_in = 1'b1;
        n_deliv = 0;
        repeat (14) cyc();
        chk("bp_delivered", n_deliv, 8);

        // drain with a word in flight
        n_deliv = 0;
        f0.push_back(6'h06);
        f0.push_back(6'h07);
        f0.push_back(6'h08);
        cyc();
        cyc();
        bus.enable = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("drain_nopop_D0", bus.pop_D0, 1'b0);
            chk("drain_nopop_D1", bus.pop_D1, 1'b0);
            cyc();
        end
        run_until_idle("drain_idle");
        chk("drain_delivered", n_deliv, 2);

        // counter wrap on the CNT_W = 2 instance
        bus.clear_cnt = 1'b1;
        cyc();
        bus.clear_cnt = 1'b0;
        for (int i = 0; i < 5; i++) f1.push_back(6'(8'h15 + i));
        bus.enable = 1'b1;
        repeat (14) cyc();
        bus.enable = 1'b0;
        run_until_idle("wrap_idle");
        chk("wrap_cnt2_d1", bus2.cnt_d1, 2'd1);
        chk("wrap_cnt_d1", bus.cnt_d1, 8'd5);

        // clear_cnt together with a departure
        f0.push_back(6'h09);
        f0.push_back(6'h0B);
        f0.push_back(6'h0C);
        bus.enable = 1'b1;
        wait_valid("clr_wait_valid");
        bus.clear_cnt = 1'b1;
        cyc();
        bus.clear_cnt = 1'b0;
        chk("clr_dep_cnt_d0", bus.cnt_d0, 8'd0);
        chk("clr_dep_cnt_d1", bus.cnt_d1, 8'd0);
        bus.enable = 1'b0;
        run_until_idle("clr_idle");

`ifdef DEST_DRAIN_CHECK_EN
        f0.push_back(6'h10);
        bus.enable = 1'b1;
        wait_valid("err_wait_valid");
        chk("err_word", bus.data_out, 6'h10);
        chk("err_set", bus.dest_err, 1'b1);
        repeat (3) cyc();
        chk("err_sticky", bus.dest_err, 1'b1);
        bus.enable = 1'b0;
        run_until_idle("err_idle");
        bus.clear_cnt = 1'b1;
        cyc();
        bus.clear_cnt = 1'b0;
        chk("err_cleared", bus.dest_err, 1'b0);
`endif

        // randomized traffic with a mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (f0.size() < 6 && $urandom_range(0, 2) == 0) f0.push_back(6'($urandom_range(0, 63)));
            if (f1.size() < 6 && $urandom_range(0, 2) == 0) f1.push_back(6'($urandom_range(0, 63)));
            bus.ready_in  = ($urandom_range(0, 3) != 0);
            bus.clear_cnt = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0) bus.enable = ~bus.enable;
            if (i == 195) bus.enable = 1'b1;
            if (i == 200) begin
                do_reset();
                bus.enable = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    chk("post_rst_no_pop", bus.pop_D0 | bus.pop_D1, 1'b0);
                    cyc();
                end
            end
            cyc();
        end

        bus.enable    = 1'b1;
        bus.ready_in  = 1'b1;
        bus.clear_cnt = 1'b0;
        repeat (30) cyc();
        bus.enable = 1'b0;
        run_until_idle("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
